mem_bus_master: RTL



---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_bus_tristate.sv | 15 +
 rtl/mem_bus_master.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus initiator.
// The TURN state is only reachable when MEMBUS_TURNAROUND_EN is defined.
package mem_bus_pkg;

    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 8;

    // Cycles from request handshake to the rsp_valid pulse.
    localparam int RD_LATENCY = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_CMD  = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_TURN    = 3'd4
    } state_t;

    function automatic logic is_rd_phase(input state_t s);
        return (s == ST_RD_CMD) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/mem_bus_tristate.sv
// Tri-state buffer for the shared memory data bus.
// Drives the bus only while drive_en is high; always returns the resolved bus value.
module mem_bus_tristate #(
    parameter int DWIDTH = 8
) (
    input  logic              drive_en,
    input  logic [DWIDTH-1:0] data_out,
    inout  wire  [DWIDTH-1:0] bus,
    output logic [DWIDTH-1:0] data_in
);

    assign bus     = drive_en ? data_out : {DWIDTH{1'bz}};
    assign data_in = bus;

endmodule

// File: rtl/mem_bus_master.sv
// Initiator-side controller turning valid/ready requests into memory-bus cycles.
// Build option MEMBUS_TURNAROUND_EN adds a dead TURN cycle after every read.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | ready for a request; mem strobes low, bus released
// ST_WRITE   | mem_wr high, bus driven with latched write data
// ST_RD_CMD  | mem_rd high, memory registers its output this cycle
// ST_RD_DATA | mem_rd high, bus sampled into rsp_rdata at cycle end
// ST_TURN    | dead cycle after a read, strobes low, bus released
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              bus_drive;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] bus_rdata;

    // Gated by rst_n so nothing can be accepted while reset is held.
    assign req_ready = rst_n && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = req_write ? ST_WRITE : ST_RD_CMD;
                end
            end
            ST_WRITE:   state_nxt = ST_IDLE;
            ST_RD_CMD:  state_nxt = ST_RD_DATA;
            ST_RD_DATA: begin
`ifdef MEMBUS_TURNAROUND_EN
                state_nxt = ST_TURN;
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_TURN:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Strobes and drive enable are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            bus_drive <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_wr    <= (state_nxt == ST_WRITE);
            mem_rd    <= is_rd_phase(state_nxt);
            bus_drive <= (state_nxt == ST_WRITE);
        end
    end

    // Address is only reloaded on a handshake, so it holds its last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            mem_addr <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state == ST_RD_DATA);
            if (state == ST_RD_DATA) begin
                rsp_rdata <= bus_rdata;
            end
        end
    end

    mem_bus_tristate #(
        .DWIDTH (DWIDTH)
    ) u_tristate (
        .drive_en (bus_drive),
        .data_out (wdata_q),
        .bus      (mem_data),
        .data_in  (bus_rdata)
    );

endmodule
